m_dm: RTL
=========

# m_dm

Memory-stage data memory for the five-stage pipeline. It supplies the load data that the write-back pipeline register captures as dm_out. The block performs word, halfword and byte stores as read-merge-writes on the clock edge, and returns aligned, zero- or sign-extended load data combinationally in the same cycle. It also emits a registered, one-cycle write trace per committed store; the verification bench uses this trace to compare against the golden model.

## Interface
Parameters:
- DEPTH, 3072: number of 32-bit words. Byte address range is 0x0000 to DEPTH*4-1.
- AW, 12: word-index width. Must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- pc  input  32  PC of the instruction in M, used for the trace
- addr  input  32  byte address, taken from the ALU output
- wdata  input  32  store data (rt value); only the low bytes are used for sh/sb
- we  input  1  store request
- store_type  input  2  0 = word, 1 = half, 2 = byte, 3 = reserved (treated as no store)
- load_type  input  3  0 = lw, 1 = lh, 2 = lhu, 3 = lb, 4 = lbu, others return 0
- rdata  output  32  load result, combinational
- align_err  output  1  access misaligned for its type, combinational
- range_err  output  1  addr >= DEPTH*4, combinational
- trace_valid  output  1  registered; high for one cycle after each committed store
- trace_pc  output  32  registered PC of the committed store
- trace_addr  output  32  registered word-aligned byte address ({addr[31:2],2'b00})
- trace_data  output  32  registered full word after the merge

## Operation
- Little-endian byte lanes: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24. Halfword addr[1]=0 selects bits 15:0.
- Word index is addr[AW+1:2].
- Alignment rules:
  - word requires addr[1:0]=0.
  - half requires addr[0]=0.
  - byte is always aligned.
  - align_err uses store_type when we=1, otherwise load_type.
- Store commit condition: we & ~align_err & ~range_err & store_type!=3.
  - On commit, the selected lanes are replaced with wdata[7:0] or wdata[15:0] replicated into the lane. Other lanes keep their old value.
  - A non-committed store changes nothing and produces no trace.
- Load path:
  - Selects the lane and extends it: lh/lb sign-extend, lhu/lbu zero-extend.
  - Out-of-range or misaligned loads return 0.
  - A load never modifies state.
- Same-cycle store and load: rdata reflects the pre-edge contents. Data written at edge N is visible on rdata from edge N onward.
- Trace:
  - At every edge, trace_valid <= commit.
  - When commit=1, trace_pc, trace_addr and trace_data load the new values.
  - Otherwise they hold their previous values.

## Timing
- Reset, asynchronous: all DEPTH words clear to 0; trace_valid, trace_pc, trace_addr and trace_data clear to 0.
- rdata, align_err and range_err are pure combinational functions of inputs and memory. They show no latency and have no reset value of their own; during reset rdata reads 0 because memory is cleared.
- Store latency is 1 edge. Trace latency is 1 edge: trace_valid is high in the cycle following the commit edge.
- Back-to-back stores to the same word on consecutive cycles merge cumulatively: the second store reads the result of the first.
- Reset asserted mid-operation overrides any pending store at that edge: memory is cleared and no trace is produced. The first edge after deassertion operates normally.
- Highest valid address DEPTH*4-1 (byte) and DEPTH*4-4 (word) are accepted. DEPTH*4 sets range_err.

## Test plan
- Reset, then lw from 0x0000, 0x2FFC and 0x1234&~3: rdata=0 and trace_valid=0 throughout.
- sw 0xDEADBEEF to 0x0010, then lw 0x0010 next cycle gives rdata=0xDEADBEEF. In the cycle after the store: trace_valid=1, trace_addr=0x10, trace_data=0xDEADBEEF, and trace_pc equals the driven pc.
- With that word present:
  - sb 0x7F to 0x0011 gives trace_data=0xDEAD7FEF.
  - sh 0x8001 to 0x0012 gives word 0x80017FEF.
  - lh 0x0012 returns 0xFFFF8001; lhu returns 0x00008001; lb 0x0013 returns 0xFFFFFF80; lbu 0x0011 returns 0x0000007F.
- Misaligned and out-of-range accesses:
  - sw to 0x0016: align_err=1, word 0x14 unchanged, no trace.
  - lh 0x0011: rdata=0 and align_err=1.
  - sw to 0x3000 (DEPTH=3072): range_err=1, no trace.
- Same cycle: sw 0x11111111 to 0x20 with lw 0x20. rdata shows old value 0 before the edge and 0x11111111 after the edge.
- Issue sw 0xAAAAAAAA to 0x40, then assert reset asynchronously mid-cycle before the next store: lw 0x40 returns 0 immediately, trace outputs are 0, and trace_valid stays 0 after deassertion.

Source files
------------

// File: rtl/m_dm.sv
// Memory-stage data memory: byte/half/word stores as read-merge-write on the clock edge,
// combinational aligned and extended loads, and a registered one-cycle trace per committed store.
module m_dm #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        range_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  localparam logic [1:0] ST_WORD = 2'd0;
  localparam logic [1:0] ST_HALF = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  // Request-only interface: a store is taken on any edge where we is high and the
  // access is legal; there is no ready, the memory accepts one access every cycle.
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   word_rd;
  logic [31:0]   merged_d;
  logic          st_mis;
  logic          ld_mis;
  logic          commit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  logic          trace_valid_q;
  logic [31:0]   trace_pc_q;
  logic [31:0]   trace_addr_q;
  logic [31:0]   trace_data_q;

  assign idx       = addr[AW+1:2];
  assign range_err = (addr >= BYTE_LIMIT);

  always_comb begin
    st_mis = 1'b0;
    case (store_type)
      ST_WORD: st_mis = (addr[1:0] != 2'b00);
      ST_HALF: st_mis = addr[0];
      default: st_mis = 1'b0;
    endcase
  end

  always_comb begin
    ld_mis = 1'b0;
    case (load_type)
      LT_LW:          ld_mis = (addr[1:0] != 2'b00);
      LT_LH, LT_LHU:  ld_mis = addr[0];
      default:        ld_mis = 1'b0;
    endcase
  end

  assign align_err = we ? st_mis : ld_mis;
  assign commit    = we & ~st_mis & ~range_err & (store_type != 2'd3);

  // Out-of-range indices never touch the array; the word reads as zero instead.
  always_comb begin
    word_rd = '0;
    if (!range_err) word_rd = mem_q[idx];
  end

  always_comb begin
    byte_sel = word_rd[7:0];
    case (addr[1:0])
      2'd0: byte_sel = word_rd[7:0];
      2'd1: byte_sel = word_rd[15:8];
      2'd2: byte_sel = word_rd[23:16];
      2'd3: byte_sel = word_rd[31:24];
      default: byte_sel = word_rd[7:0];
    endcase
    half_sel = addr[1] ? word_rd[31:16] : word_rd[15:0];
  end

  always_comb begin
    rdata = '0;
    if (!range_err && !ld_mis) begin
      case (load_type)
        LT_LW:   rdata = word_rd;
        LT_LH:   rdata = {{16{half_sel[15]}}, half_sel};
        LT_LHU:  rdata = {16'h0000, half_sel};
        LT_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
        LT_LBU:  rdata = {24'h000000, byte_sel};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    merged_d = word_rd;
    case (store_type)
      ST_WORD: merged_d = wdata;
      ST_HALF: begin
        if (addr[1]) merged_d[31:16] = wdata[15:0];
        else         merged_d[15:0]  = wdata[15:0];
      end
      ST_BYTE: begin
        case (addr[1:0])
          2'd0: merged_d[7:0]   = wdata[7:0];
          2'd1: merged_d[15:8]  = wdata[7:0];
          2'd2: merged_d[23:16] = wdata[7:0];
          2'd3: merged_d[31:24] = wdata[7:0];
          default: merged_d = word_rd;
        endcase
      end
      default: merged_d = word_rd;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= merged_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= commit;
      if (commit) begin
        trace_pc_q   <= pc;
        trace_addr_q <= {addr[31:2], 2'b00};
        trace_data_q <= merged_d;
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule
